// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM generator.
// Optional build macro: PWM_CENTER_ALIGN_EN selects the up/down (centre-aligned) counter.
package pwm_pkg;

  localparam int unsigned PWM_NCH_DEF = 4;
  localparam int unsigned PWM_CW_DEF  = 16;
  localparam int unsigned PWM_PER_MIN = 2;

  typedef logic [PWM_CW_DEF-1:0] pwm_cnt_t;

  typedef enum logic {
    PWM_UP,
    PWM_DN
  } pwm_dir_e;

endpackage

// File: rtl/pwm_multi_gen_if.sv
// Control/status bundle of the PWM generator. Signal names follow the generator's view:
// the slave modport is the generator, the master modport drives it.
interface pwm_multi_gen_if #(
  parameter int unsigned NCH = pwm_pkg::PWM_NCH_DEF,
  parameter int unsigned CW  = pwm_pkg::PWM_CW_DEF
);

  logic              ena_i;
  logic [CW-1:0]     period_i;
  logic [NCH*CW-1:0] duty_i;
  logic [NCH-1:0]    duty_we_i;
  logic [NCH-1:0]    pwm_o;
  logic              sync_o;
  logic              pend_o;

  modport master (
    output ena_i, period_i, duty_i, duty_we_i,
    input  pwm_o, sync_o, pend_o
  );

  modport slave (
    input  ena_i, period_i, duty_i, duty_we_i,
    output pwm_o, sync_o, pend_o
  );

endinterface

// File: rtl/pwm_ch_cmp.sv
// One PWM channel: shadow and active duty registers plus the registered compare output.
module pwm_ch_cmp #(
  parameter int unsigned CW = pwm_pkg::PWM_CW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          ena_i,
  input  logic          le_i,
  input  logic [CW-1:0] cnt_nxt_i,
  input  logic [CW-1:0] duty_i,
  input  logic          duty_we_i,
  output logic          pwm_o
);

  logic [CW-1:0] shadow_q, shadow_d;
  logic [CW-1:0] act_q, act_d;
  logic          pwm_q, pwm_d;

  // Next-state: load event takes the old shadow, a write lands in the shadow afterwards.
  always_comb begin
    act_d    = le_i ? shadow_q : act_q;
    shadow_d = duty_we_i ? duty_i : shadow_q;
    // Compare against next count and next duty so the flop lines up with the counter.
    pwm_d    = ena_i && (cnt_nxt_i < act_d);
  end

  // Channel state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_q <= '0;
      act_q    <= '0;
      pwm_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      act_q    <= act_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_multi_gen.sv
// NCH-channel phase-aligned PWM generator with double-buffered duty and period.
// Build macro PWM_CENTER_ALIGN_EN: centre-aligned up/down counting; default is saw-tooth.
module pwm_multi_gen
  import pwm_pkg::*;
#(
  parameter int unsigned NCH     = PWM_NCH_DEF,
  parameter int unsigned CW      = PWM_CW_DEF,
  parameter int unsigned PER_RST = 20000
) (
  input logic             clk_i,
  input logic             rst_i,
  pwm_multi_gen_if.slave  bus_io
);

  localparam logic [CW-1:0] PerMin = CW'(PWM_PER_MIN);
  localparam logic [CW-1:0] PerRst = CW'(PER_RST);
  localparam logic [CW-1:0] One    = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] per_q, per_d;
  logic          ena_q;
  logic          sync_q;
  logic          pend_q, pend_d;
  logic          wrap;
  logic          le;
  logic [NCH-1:0] pwm_w;

`ifdef PWM_CENTER_ALIGN_EN
  pwm_dir_e dir_q, dir_d;
  logic     go_dn;
`endif

  // Counter, period and load-event next-state logic.
  always_comb begin
`ifdef PWM_CENTER_ALIGN_EN
    // The top of the ramp turns the count around even before dir_q has flipped.
    go_dn = (dir_q == PWM_DN) || (cnt_q == per_q - One);
    wrap  = go_dn && (cnt_q == One);
`else
    wrap  = (cnt_q == per_q - One);
`endif
    le     = bus_io.ena_i && (!ena_q || wrap);
    per_d  = per_q;
    cnt_d  = '0;
    pend_d = pend_q;
    if (le) begin
      per_d = (bus_io.period_i < PerMin) ? PerMin : bus_io.period_i;
    end
    if (bus_io.ena_i && !le) begin
`ifdef PWM_CENTER_ALIGN_EN
      cnt_d = go_dn ? cnt_q - One : cnt_q + One;
`else
      cnt_d = cnt_q + One;
`endif
    end
`ifdef PWM_CENTER_ALIGN_EN
    dir_d = dir_q;
    if (!bus_io.ena_i || le) begin
      dir_d = PWM_UP;
    end else if (go_dn) begin
      dir_d = PWM_DN;
    end
`endif
    // A write in the load-event cycle keeps pend set: its value is still waiting.
    if (|bus_io.duty_we_i) begin
      pend_d = 1'b1;
    end else if (le) begin
      pend_d = 1'b0;
    end
  end

  // Shared timing state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      per_q  <= PerRst;
      ena_q  <= 1'b0;
      sync_q <= 1'b0;
      pend_q <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      dir_q  <= PWM_UP;
`endif
    end else begin
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      ena_q  <= bus_io.ena_i;
      sync_q <= le;
      pend_q <= pend_d;
`ifdef PWM_CENTER_ALIGN_EN
      dir_q  <= dir_d;
`endif
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    pwm_ch_cmp #(
      .CW(CW)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .ena_i     (bus_io.ena_i),
      .le_i      (le),
      .cnt_nxt_i (cnt_d),
      .duty_i    (bus_io.duty_i[k*CW +: CW]),
      .duty_we_i (bus_io.duty_we_i[k]),
      .pwm_o     (pwm_w[k])
    );
  end

  assign bus_io.pwm_o  = pwm_w;
  assign bus_io.sync_o = sync_q;
  assign bus_io.pend_o = pend_q;

endmodule
